// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch and data requester handshakes,
// the single memory port, and debug visibility of the arbiter FSM.
// Handshake: a requester raises *_req with stable address/data and holds it
// until the matching *_ack, which is a single-cycle pulse; the arbiter
// snapshots the request at grant, so later input changes are ignored.
interface mem_port_arbiter_if;
    // fetch requester
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    // data requester
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_tam;
    logic        d_ack;
    // shared read return
    logic [31:0] rdata;
    // memory port
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_tam;
    logic [31:0] mem_rdata;
    // status and debug
    logic        busy;
    logic [1:0]  dbg_state;
    logic        dbg_last_grant;

    // arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_tam, mem_rdata,
        output i_ack, d_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata,
        output mem_tam, busy, dbg_state, dbg_last_grant
    );

    // requester / memory-model side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_tam, mem_rdata,
        input  i_ack, d_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_tam, busy, dbg_state, dbg_last_grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between an
// instruction-fetch requester and a data requester.
// FSM IDLE -> ACCESS (LAT cycles) -> RESP (one-cycle ack) -> IDLE.
// Optional macro ARB_ROUND_ROBIN_EN: contended grants alternate between the
// requesters; without it, data always wins a contended grant.
module mem_port_arbiter #(
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // LAT of 0 behaves as 1; counter is 4 bits so cap at 15.
    localparam int         LAT_E    = (LAT < 1) ? 1 : ((LAT > 15) ? 15 : LAT);
    localparam logic [3:0] CNT_LOAD = 4'(LAT_E - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        last_grant;   // 0 = fetch, 1 = data; also the current owner
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [1:0]  tam_r;
    logic [31:0] rdata_r;
    logic        grant_valid;
    logic        grant_data;

    // Pick the winner for a grant taken in IDLE.
    always_comb begin
        grant_valid = bus.i_req | bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.i_req && bus.d_req) begin
            grant_data = ~last_grant;
        end else begin
            grant_data = bus.d_req;
        end
`else
        grant_data = bus.d_req;
`endif
    end

    // FSM, request snapshot, latency counter and read-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            we_r       <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            tam_r      <= 2'b00;
            rdata_r    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_data;
                        if (grant_data) begin
                            addr_r  <= bus.d_addr;
                            wdata_r <= bus.d_wdata;
                            we_r    <= bus.d_we;
                            tam_r   <= bus.d_tam;
                        end else begin
                            addr_r  <= bus.i_addr;
                            wdata_r <= 32'd0;
                            we_r    <= 1'b0;
                            tam_r   <= 2'b00;
                        end
                        cnt   <= CNT_LOAD;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // stores leave the read-data register untouched
                        if (!we_r) begin
                            rdata_r <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // no grant here: one idle cycle separates transactions
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode from state so reset clears them immediately.
    assign bus.mem_en         = (state == ACCESS);
    assign bus.mem_we         = (state == ACCESS) & we_r;
    assign bus.i_ack          = (state == RESP) & ~last_grant;
    assign bus.d_ack          = (state == RESP) & last_grant;
    assign bus.busy           = (state != IDLE);
    assign bus.mem_addr       = addr_r;
    assign bus.mem_wdata      = wdata_r;
    assign bus.mem_tam        = tam_r;
    assign bus.rdata          = rdata_r;
    assign bus.dbg_state      = state;
    assign bus.dbg_last_grant = last_grant;

endmodule
